// File: rtl/msrv32_instr_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// The queue side uses the slave modport; fetch and decode drive via master.
interface msrv32_instr_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              imem_valid_in;
  logic [31:0]       imem_instr_in;
  logic [31:0]       imem_pc_in;
  logic              imem_ready_out;
  logic              dec_ready_in;
  logic              dec_valid_out;
  logic [6:0]        opcode_out;
  logic [24:0]       instr_out;
  logic [31:0]       pc_out;
  logic [PTR_W:0]    count_out;

  modport slave (
    input  imem_valid_in, imem_instr_in, imem_pc_in, dec_ready_in,
    output imem_ready_out, dec_valid_out, opcode_out, instr_out, pc_out, count_out
  );

  modport master (
    output imem_valid_in, imem_instr_in, imem_pc_in, dec_ready_in,
    input  imem_ready_out, dec_valid_out, opcode_out, instr_out, pc_out, count_out
  );
endinterface

// File: rtl/msrv32_instr_queue.sv
// Instruction prefetch FIFO between imem and decode, show-ahead head output.
// Optional INSTR_QUEUE_BYPASS_EN: empty-queue push is forwarded to decode the same cycle.
module msrv32_instr_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 flush_in,
  msrv32_instr_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, count;
  logic           full, empty, push, pop, wr_en, byp;
  entry_t         head;

  // Extra pointer MSB distinguishes full from empty; difference is occupancy.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_comb begin
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = empty & q.imem_valid_in & ~flush_in;
`else
    byp = 1'b0;
`endif
    push  = q.imem_valid_in & ~full & ~flush_in;
    pop   = ~empty & q.dec_ready_in & ~flush_in;
    // A bypassed entry taken by decode this cycle never lands in storage.
    wr_en = push & ~(byp & q.dec_ready_in);
    head  = '{pc: 32'h0, instr: NOP};
    if (!empty)   head = mem[rd_ptr[PTR_W-1:0]];
    else if (byp) head = '{pc: q.imem_pc_in, instr: q.imem_instr_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= '{pc: q.imem_pc_in, instr: q.imem_instr_in};
  end

  assign q.imem_ready_out = ~full;
  assign q.dec_valid_out  = ~empty | byp;
  assign q.opcode_out     = head.instr[6:0];
  assign q.instr_out      = head.instr[31:7];
  assign q.pc_out         = head.pc;
  assign q.count_out      = count;
endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Directed checks for msrv32_instr_queue: reset, fill/drain, wrap, full+pop, flush, bypass.
module tb_msrv32_instr_queue;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic flush_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  msrv32_instr_queue_if #(.DEPTH(4)) q ();

  msrv32_instr_queue #(.DEPTH(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .flush_in (flush_in),
    .q        (q)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Test instruction tied to its pc: opcode 7'h33, pc in the upper bits.
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[19:0], 12'h0B3};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    q.imem_valid_in = v;
    q.imem_pc_in    = pc;
    q.imem_instr_in = ins(pc);
    q.dec_ready_in  = rdy;
    flush_in        = fl;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", {31'h0, q.dec_valid_out}, 32'h0);
    chk("rst_ready", {31'h0, q.imem_ready_out}, 32'h1);
    chk("rst_count", {29'h0, q.count_out}, 32'h0);
    chk("rst_opcode", {25'h0, q.opcode_out}, 32'h13);
    chk("rst_pc", q.pc_out, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Fill four, attempt a fifth, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(k*4), 1'b0, 1'b0);
      @(negedge clk_in);
    end
    chk("fill_count", {29'h0, q.count_out}, 32'h4);
    chk("fill_ready", {31'h0, q.imem_ready_out}, 32'h0);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("ovf_count", {29'h0, q.count_out}, 32'h4);
    chk("head_opcode", {25'h0, q.opcode_out}, 32'h33);
    chk("head_instr", {7'h0, q.instr_out}, 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", q.pc_out, 32'(k*4));
      @(negedge clk_in);
    end
    chk("drain_count", {29'h0, q.count_out}, 32'h0);
    chk("drain_valid", {31'h0, q.dec_valid_out}, 32'h0);

    // Hold occupancy at 2 with concurrent push/pop across pointer wrap.
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge clk_in);
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    @(negedge clk_in);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(32'h48 + i*4), 1'b1, 1'b0);
      chk("wrap_pc", q.pc_out, 32'(32'h40 + i*4));
      chk("wrap_instr", {7'h0, q.instr_out}, ins(32'(32'h40 + i*4)) >> 7);
      chk("wrap_count", {29'h0, q.count_out}, 32'h2);
      @(negedge clk_in);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_tail0", q.pc_out, 32'h68);
    @(negedge clk_in);
    chk("wrap_tail1", q.pc_out, 32'h6C);
    @(negedge clk_in);
    chk("wrap_empty", {29'h0, q.count_out}, 32'h0);

    // Full with push and pop: pop taken, push rejected.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(32'h80 + k*4), 1'b0, 1'b0);
      @(negedge clk_in);
    end
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    @(negedge clk_in);
    chk("fullpop_count", {29'h0, q.count_out}, 32'h3);
    chk("fullpop_pc", q.pc_out, 32'h84);

    // Flush beats same-cycle push and pop.
    drive(1'b1, 32'h300, 1'b1, 1'b1);
    @(negedge clk_in);
    chk("flush_count", {29'h0, q.count_out}, 32'h0);
    chk("flush_valid", {31'h0, q.dec_valid_out}, 32'h0);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    @(negedge clk_in);
    chk("postflush_pc", q.pc_out, 32'h100);
    chk("postflush_count", {29'h0, q.count_out}, 32'h1);

    // Asynchronous reset mid-stream at count 3.
    drive(1'b1, 32'h104, 1'b0, 1'b0);
    @(negedge clk_in);
    drive(1'b1, 32'h108, 1'b0, 1'b0);
    @(negedge clk_in);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", {29'h0, q.count_out}, 32'h3);
    rst_n_in = 1'b0;
    #1;
    chk("mrst_valid", {31'h0, q.dec_valid_out}, 32'h0);
    chk("mrst_count", {29'h0, q.count_out}, 32'h0);
    chk("mrst_opcode", {25'h0, q.opcode_out}, 32'h13);
    chk("mrst_instr", {7'h0, q.instr_out}, 32'h0);
    chk("mrst_ready", {31'h0, q.imem_ready_out}, 32'h1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Push into empty queue with decode ready.
    q.imem_valid_in = 1'b1;
    q.imem_pc_in    = 32'h20;
    q.imem_instr_in = 32'h0050_0093;
    q.dec_ready_in  = 1'b1;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_valid", {31'h0, q.dec_valid_out}, 32'h1);
    chk("byp_opcode", {25'h0, q.opcode_out}, 32'h13);
    chk("byp_instr", {7'h0, q.instr_out}, 32'h000A001);
    chk("byp_pc", q.pc_out, 32'h20);
    @(negedge clk_in);
    q.imem_valid_in = 1'b0;
    #1;
    chk("byp_count", {29'h0, q.count_out}, 32'h0);
    chk("byp_after_valid", {31'h0, q.dec_valid_out}, 32'h0);
`else
    chk("nobyp_valid", {31'h0, q.dec_valid_out}, 32'h0);
    chk("nobyp_pc", q.pc_out, 32'h0);
    @(negedge clk_in);
    q.imem_valid_in = 1'b0;
    q.dec_ready_in  = 1'b0;
    #1;
    chk("nobyp_count", {29'h0, q.count_out}, 32'h1);
    chk("nobyp_valid1", {31'h0, q.dec_valid_out}, 32'h1);
    chk("nobyp_opcode", {25'h0, q.opcode_out}, 32'h13);
    chk("nobyp_instr", {7'h0, q.instr_out}, 32'h000A001);
    chk("nobyp_pc1", q.pc_out, 32'h20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
